// File: rtl/instruction_fetch_latch.sv
// Multi-cycle fetch stage: one req/ack memory read per accepted fetch_start, word held in the IR and decoded.
// Optional macro FETCH_TIMEOUT_EN aborts a fetch that sees no mem_ack within TIMEOUT request cycles.
module instruction_fetch_latch #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_start,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               busy,
    output logic               instr_valid,
    output logic               fetch_err,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [15:0]        imm16,
    output logic               ext_op
);

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        REQ_S  = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t             state_r, state_nx_s;
    logic               accept_s, misalign_s, timeout_s, limit_hit_s;
    logic               mem_req_nx_s, busy_nx_s, valid_nx_s, err_nx_s;
    logic               mem_req_r, busy_r, valid_r, err_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [INSTR_W-1:0] ir_r;

`ifdef FETCH_TIMEOUT_EN
    localparam int            CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] cnt_r;

    // The Nth request cycle without ack is the last one; an ack in that same cycle still wins.
    assign limit_hit_s = (cnt_r == LIMIT_C);

    // Wait counter: cleared when a fetch is accepted, counts ack-less request cycles, saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == REQ_S) && !mem_ack && (cnt_r != SAT_C)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT;
    assign limit_hit_s      = 1'b0;
`endif

    // Next-state logic for the IDLE/REQ/DONE handshake sequencer.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        misalign_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE_S: begin
                if (fetch_start && (pc_in[1:0] == 2'b00)) begin
                    accept_s   = 1'b1;
                    state_nx_s = REQ_S;
                end else if (fetch_start) begin
                    misalign_s = 1'b1;
                    state_nx_s = IDLE_S;
                end else begin
                    state_nx_s = IDLE_S;
                end
            end
            REQ_S: begin
                if (mem_ack) begin
                    state_nx_s = DONE_S;
                end else if (limit_hit_s) begin
                    timeout_s  = 1'b1;
                    state_nx_s = IDLE_S;
                end else begin
                    state_nx_s = REQ_S;
                end
            end
            DONE_S:  state_nx_s = IDLE_S;
            default: state_nx_s = IDLE_S;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so every output is a flop.
    always_comb begin
        mem_req_nx_s = (state_nx_s == REQ_S);
        busy_nx_s    = (state_nx_s != IDLE_S);
        valid_nx_s   = (state_nx_s == DONE_S);
        err_nx_s     = misalign_s | timeout_s;
    end

    // State, output, address and IR registers; reset clears everything including the IR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE_S;
            mem_req_r <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            ir_r      <= {INSTR_W{1'b0}};
        end else begin
            state_r   <= state_nx_s;
            mem_req_r <= mem_req_nx_s;
            busy_r    <= busy_nx_s;
            valid_r   <= valid_nx_s;
            err_r     <= err_nx_s;
            addr_r    <= accept_s ? pc_in : addr_r;
            ir_r      <= ((state_r == REQ_S) && mem_ack) ? mem_rdata : ir_r;
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_addr    = addr_r;
    assign busy        = busy_r;
    assign instr_valid = valid_r;
    assign fetch_err   = err_r;
    assign instr       = ir_r;
    assign opcode      = ir_r[31:26];
    assign rs          = ir_r[25:21];
    assign rt          = ir_r[20:16];
    assign imm16       = ir_r[15:0];
    // Logical immediates (ANDI/ORI/XORI/LUI, opcodes 0x0C-0x0F) zero-extend; all others sign-extend.
    assign ext_op      = (ir_r[31:28] == 4'b0011) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_instruction_fetch_latch.sv
// Scoreboard bench for instruction_fetch_latch: stimulus pushes expected pulses, a monitor pops and compares.
module tb_instruction_fetch_latch;

    logic        clk = 1'b0;
    logic        reset, fetch_start, mem_ack;
    logic [31:0] pc_in, mem_rdata;
    logic        mem_req, busy, instr_valid, fetch_err, ext_op;
    logic [31:0] mem_addr, instr;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [15:0] imm16;

    instruction_fetch_latch #(.ADDR_W(32), .INSTR_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .instr_valid(instr_valid), .fetch_err(fetch_err), .instr(instr),
        .opcode(opcode), .rs(rs), .rt(rt), .imm16(imm16), .ext_op(ext_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] word;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ir_model;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_opcode(input logic [31:0] w); return w / 32'd67108864; endfunction
    function automatic logic [31:0] m_rs(input logic [31:0] w); return (w / 32'd2097152) % 32'd32; endfunction
    function automatic logic [31:0] m_rt(input logic [31:0] w); return (w / 32'd65536) % 32'd32; endfunction
    function automatic logic [31:0] m_imm(input logic [31:0] w); return w % 32'd65536; endfunction
    function automatic logic [31:0] m_ext(input logic [31:0] w);
        logic [31:0] op;
        op = m_opcode(w);
        return (op >= 32'd12 && op <= 32'd15) ? 32'd0 : 32'd1;
    endfunction

    // Monitor: every instr_valid/fetch_err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (instr_valid === 1'b1 || fetch_err === 1'b1) begin
            if (q.size() == 0) begin
                chk(1'b0, "unexpected_pulse", {30'd0, fetch_err, instr_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({fetch_err, instr_valid} == {e.is_err, !e.is_err}, "pulse_kind",
                    {30'd0, fetch_err, instr_valid}, {30'd0, e.is_err, !e.is_err});
                chk(instr == e.word, "instr", instr, e.word);
                chk({26'd0, opcode} == m_opcode(e.word), "opcode", {26'd0, opcode}, m_opcode(e.word));
                chk({27'd0, rs} == m_rs(e.word), "rs", {27'd0, rs}, m_rs(e.word));
                chk({27'd0, rt} == m_rt(e.word), "rt", {27'd0, rt}, m_rt(e.word));
                chk({16'd0, imm16} == m_imm(e.word), "imm16", {16'd0, imm16}, m_imm(e.word));
                chk({31'd0, ext_op} == m_ext(e.word), "ext_op", {31'd0, ext_op}, m_ext(e.word));
            end
        end
    end

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] word, input int delay, input bit poke);
        @(negedge clk);
        fetch_start = 1'b1;
        pc_in       = pc;
        if (pc[1:0] != 2'b00) begin
            q.push_back('{1'b1, ir_model});
            @(negedge clk);
            fetch_start = 1'b0;
            chk(mem_req == 1'b0, "misalign_noreq", {31'd0, mem_req}, 32'd0);
            chk(fetch_err == 1'b1, "misalign_err", {31'd0, fetch_err}, 32'd1);
            @(negedge clk);
            chk(fetch_err == 1'b0 && busy == 1'b0, "misalign_once", {30'd0, fetch_err, busy}, 32'd0);
        end else begin
            @(negedge clk);
            fetch_start = 1'b0;
            chk(mem_req == 1'b1 && mem_addr == pc, "req_rise", mem_addr, pc);
            for (int d = 0; d < delay; d++) begin
                if (poke && d == delay / 2) begin
                    fetch_start = 1'b1;
                    pc_in       = $urandom;
                end
                @(negedge clk);
                fetch_start = 1'b0;
                chk(mem_req == 1'b1 && mem_addr == pc, "addr_stable", mem_addr, pc);
            end
            mem_ack   = 1'b1;
            mem_rdata = word;
            q.push_back('{1'b0, word});
            ir_model  = word;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk(instr_valid == 1'b1 && mem_req == 1'b0 && busy == 1'b1, "done_cycle",
                {29'd0, instr_valid, mem_req, busy}, 32'd5);
            @(negedge clk);
            chk(instr_valid == 1'b0 && busy == 1'b0, "back_idle", {30'd0, instr_valid, busy}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ext_val;
        int          cyc;
        reset = 1'b1; fetch_start = 1'b0; mem_ack = 1'b0; pc_in = 32'd0; mem_rdata = 32'd0;
        ir_model = 32'd0;
        repeat (3) @(negedge clk);
        chk({mem_req, busy, instr_valid, fetch_err} == 4'b0000, "reset_ctrl",
            {28'd0, mem_req, busy, instr_valid, fetch_err}, 32'd0);
        chk(instr == 32'd0 && mem_addr == 32'd0 && ext_op == 1'b1, "reset_data", instr, 32'd0);
        reset = 1'b0;

        // Directed cases: sign-extending and zero-extending words, misaligned PC, delayed ack with poke.
        do_fetch(32'h40, 32'h2C22BEEF, 0, 1'b0);
        chk(opcode == 6'h0B && rs == 5'd1 && rt == 5'd2 && imm16 == 16'hBEEF, "t1_fields", instr, 32'h2C22BEEF);
        ext_val = {{16{ext_op & imm16[15]}}, imm16};
        chk(ext_val == 32'hFFFFBEEF, "t1_extend", ext_val, 32'hFFFFBEEF);
        do_fetch(32'h44, 32'h3443BEEF, 0, 1'b0);
        ext_val = {{16{ext_op & imm16[15]}}, imm16};
        chk(ext_val == 32'h0000BEEF, "t2_extend", ext_val, 32'h0000BEEF);
        do_fetch(32'h42, 32'h0, 0, 1'b0);
        chk(instr == 32'h3443BEEF, "t3_ir_kept", instr, 32'h3443BEEF);
        do_fetch(32'h100, 32'h8C4A0010, 5, 1'b1);

        // Ack while idle must not touch the IR.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEADDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk(instr == ir_model && busy == 1'b0, "idle_ack_ignored", instr, ir_model);

        // Randomized fetches.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] pc;
            pc = $urandom;
            if ($urandom_range(3, 0) != 0) pc[1:0] = 2'b00;
            do_fetch(pc, $urandom, $urandom_range(6, 0), 1'(($urandom_range(1, 0))));
        end

        // Reset in the middle of a request aborts with no pulse and clears the IR.
        @(negedge clk);
        fetch_start = 1'b1; pc_in = 32'h200;
        @(negedge clk);
        fetch_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ir_model = 32'd0;
        chk(mem_req == 1'b0 && busy == 1'b0 && instr == 32'd0, "reset_abort", instr, 32'd0);
        @(negedge clk);
        chk(busy == 1'b0, "reset_stays_idle", {31'd0, busy}, 32'd0);

        // No ack at all.
        @(negedge clk);
        fetch_start = 1'b1; pc_in = 32'h300;
        @(negedge clk);
        fetch_start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cyc = 0;
        q.push_back('{1'b1, ir_model});
        while (fetch_err != 1'b1 && cyc < 40) begin
            if (mem_req) cyc++;
            @(negedge clk);
        end
        chk(cyc == 15, "timeout_cycles", cyc, 32'd15);
        chk(mem_req == 1'b0 && instr == ir_model, "timeout_state", instr, ir_model);
        @(negedge clk);
        do_fetch(32'h304, 32'h0C000001, 14, 1'b0);
`else
        cyc = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy && mem_req) cyc++;
        end
        chk(cyc == 40, "no_timeout_wait", cyc, 32'd40);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ir_model = 32'd0;
`endif
        do_fetch(32'h400, 32'h3C0F1234, 1, 1'b0);

        repeat (3) @(negedge clk);
        chk(q.size() == 0, "pending_expectations", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
